// File: rtl/sq_fwd_pkg.sv
// Shared types and constants for the store queue: entry packet layout and the
// default geometry.
package sq_fwd_pkg;

   localparam int SQ_DEPTH = 8;
   localparam int SQ_IDXW  = $clog2(SQ_DEPTH);

   typedef struct packed {
      logic        ready;
      logic [3:0]  usebytes;
      logic [31:0] addr;
      logic [31:0] data;
   } sq_entry_t;

   localparam sq_entry_t SQ_ZERO = '0;

endpackage

// File: rtl/sq_fwd_select.sv
// Age-ordered byte forwarding search: walks the older stores youngest-first and
// lets the first ready, word-matching store claim each requested byte lane.
module sq_fwd_select
   import sq_fwd_pkg::*;
#(
   parameter int DEPTH = SQ_DEPTH,
   parameter int IDXW  = $clog2(DEPTH)
) (
   input  sq_entry_t [DEPTH-1:0] entries,
   input  logic [IDXW-1:0]       head,
   input  logic [IDXW:0]         n_older,
   input  logic                  ld_valid,
   input  logic [31:0]           ld_addr,
   input  logic [3:0]            ld_usebytes,
   output logic [3:0]            fwd_bytes,
   output logic [31:0]           fwd_data,
   output logic                  fwd_stall
);

   localparam int PW = IDXW + 1;

   logic [3:0]      need;
   logic [3:0]      bytes;
   logic [31:0]     data;
   logic            stall;
   logic [PW-1:0]   pos;
   logic [IDXW-1:0] idx;
   sq_entry_t       e;
   logic            unused_bits;

   // Byte offset bits never take part in the word match.
   assign unused_bits = ^{ld_addr[1:0], entries};

   always_comb begin
      need  = ld_usebytes;
      bytes = '0;
      data  = '0;
      stall = 1'b0;
      pos   = '0;
      idx   = '0;
      e     = SQ_ZERO;
      for (int k = 0; k < DEPTH; k++) begin
         if ((PW'(k) < n_older) && (need != 4'b0000) && !stall) begin
            pos = n_older - PW'(k + 1);
            idx = head + pos[IDXW-1:0];
            e   = entries[idx];
            if (!e.ready) begin
               stall = 1'b1;
            end else if (e.addr[31:2] == ld_addr[31:2]) begin
               for (int b = 0; b < 4; b++) begin
                  if (need[b] && e.usebytes[b]) begin
                     bytes[b]       = 1'b1;
                     data[8*b +: 8] = e.data[8*b +: 8];
                     need[b]        = 1'b0;
                  end
               end
            end
         end
      end
   end

   assign fwd_stall = ld_valid && stall;
   assign fwd_bytes = (ld_valid && !stall) ? bytes : 4'b0000;
   assign fwd_data  = (ld_valid && !stall) ? data  : 32'h0;

endmodule

// File: rtl/sq_fwd.sv
// Circular store queue with wrap-bit pointers, multi-lane dispatch/execute/retire,
// full squash and store-to-load forwarding.
module sq_fwd
   import sq_fwd_pkg::*;
#(
   parameter int DEPTH  = SQ_DEPTH,
   parameter int DISP_W = 3,
   parameter int EXE_W  = 2,
   parameter int RET_W  = 3,
   parameter int IDXW   = $clog2(DEPTH)
) (
   input  logic                          clock,
   input  logic                          reset,
`ifdef TEST_MODE
   output sq_entry_t [DEPTH-1:0]         sq_display,
   output logic [IDXW:0]                 head_dis,
   output logic [IDXW:0]                 tail_dis,
   output logic [IDXW:0]                 filled_num_dis,
`endif
   output logic [DISP_W-1:0]             struct_stall,
   input  logic [DISP_W-1:0]             dispatch,
   output logic [DISP_W-1:0][IDXW-1:0]   new_entry_idx,
   input  logic [EXE_W-1:0]              exe_valid,
   input  logic [EXE_W-1:0][IDXW-1:0]    exe_idx,
   input  sq_entry_t [EXE_W-1:0]         exe_store,
   input  logic [RET_W-1:0]              retire,
   output sq_entry_t [RET_W-1:0]         cache_wb,
   input  logic                          squash,
   input  logic                          ld_valid,
   input  logic [31:0]                   ld_addr,
   input  logic [3:0]                    ld_usebytes,
   input  logic [IDXW:0]                 ld_tail,
   output logic [3:0]                    fwd_bytes,
   output logic [31:0]                   fwd_data,
   output logic                          fwd_stall
);

   localparam int PW = IDXW + 1;

   logic [PW-1:0]         head_ptr, tail_ptr, count;
   logic [PW-1:0]         head_n, tail_n, count_n;
   logic [PW-1:0]         ndisp, nret, free_slots;
   logic [PW-1:0]         n_raw, n_older;
   logic [IDXW-1:0]       off;
   sq_entry_t [DEPTH-1:0] entries, entries_n;

   always_comb begin
      ndisp = '0;
      nret  = '0;
      for (int i = 0; i < DISP_W; i++) ndisp = ndisp + PW'(dispatch[i]);
      for (int i = 0; i < RET_W; i++)  nret  = nret + PW'(retire[i]);
   end

   always_comb begin
      off = '0;
      for (int i = 0; i < DISP_W; i++) begin
         new_entry_idx[i] = tail_ptr[IDXW-1:0] + off;
         off              = off + IDXW'(dispatch[i]);
      end
   end

   // Stall looks at the current occupancy only; space freed by a retire this cycle is not reused.
   assign free_slots = PW'(DEPTH) - count;

   always_comb begin
      for (int i = 0; i < DISP_W; i++) struct_stall[i] = (free_slots < PW'(i + 1));
   end

   always_comb begin
      for (int i = 0; i < RET_W; i++) begin
         cache_wb[i] = (PW'(i) < count) ? entries[head_ptr[IDXW-1:0] + IDXW'(i)] : SQ_ZERO;
      end
   end

   always_comb begin
      entries_n = entries;
      head_n    = head_ptr + nret;
      tail_n    = tail_ptr + ndisp;
      count_n   = count + ndisp - nret;
      if (squash) begin
         entries_n = '0;
         tail_n    = head_n;
         count_n   = '0;
      end else begin
         for (int p = 0; p < EXE_W; p++) begin
            if (exe_valid[p]) entries_n[exe_idx[p]] = exe_store[p];
         end
         for (int i = 0; i < DISP_W; i++) begin
            if (dispatch[i]) entries_n[new_entry_idx[i]] = SQ_ZERO;
         end
         for (int i = 0; i < RET_W; i++) begin
            if (retire[i]) entries_n[head_ptr[IDXW-1:0] + IDXW'(i)] = SQ_ZERO;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         entries  <= '0;
      end else begin
         head_ptr <= head_n;
         tail_ptr <= tail_n;
         count    <= count_n;
         entries  <= entries_n;
      end
   end

   // A snapshot behind the current head means every older store has retired.
   assign n_raw   = ld_tail - head_ptr;
   assign n_older = (n_raw > PW'(DEPTH)) ? '0 : n_raw;

   sq_fwd_select #(.DEPTH(DEPTH), .IDXW(IDXW)) u_select (
      .entries     (entries),
      .head        (head_ptr[IDXW-1:0]),
      .n_older     (n_older),
      .ld_valid    (ld_valid),
      .ld_addr     (ld_addr),
      .ld_usebytes (ld_usebytes),
      .fwd_bytes   (fwd_bytes),
      .fwd_data    (fwd_data),
      .fwd_stall   (fwd_stall)
   );

`ifdef TEST_MODE
   assign sq_display     = entries;
   assign head_dis       = head_ptr;
   assign tail_dis       = tail_ptr;
   assign filled_num_dis = count;
`endif

endmodule

// File: tb/tb_sq_fwd.sv
// Directed bench for sq_fwd: fill, execute, retire, wrap, forward, squash and
// same-entry execute conflict at DEPTH=8.
module tb_sq_fwd;
   import sq_fwd_pkg::*;

   logic                 clock;
   logic                 reset;
   logic [2:0]           struct_stall;
   logic [2:0]           dispatch;
   logic [2:0][2:0]      new_entry_idx;
   logic [1:0]           exe_valid;
   logic [1:0][2:0]      exe_idx;
   sq_entry_t [1:0]      exe_store;
   logic [2:0]           retire;
   sq_entry_t [2:0]      cache_wb;
   logic                 squash;
   logic                 ld_valid;
   logic [31:0]          ld_addr;
   logic [3:0]           ld_usebytes;
   logic [3:0]           ld_tail;
   logic [3:0]           fwd_bytes;
   logic [31:0]          fwd_data;
   logic                 fwd_stall;

   int total = 0;
   int bad   = 0;

   sq_fwd dut (
      .clock         (clock),
      .reset         (reset),
      .struct_stall  (struct_stall),
      .dispatch      (dispatch),
      .new_entry_idx (new_entry_idx),
      .exe_valid     (exe_valid),
      .exe_idx       (exe_idx),
      .exe_store     (exe_store),
      .retire        (retire),
      .cache_wb      (cache_wb),
      .squash        (squash),
      .ld_valid      (ld_valid),
      .ld_addr       (ld_addr),
      .ld_usebytes   (ld_usebytes),
      .ld_tail       (ld_tail),
      .fwd_bytes     (fwd_bytes),
      .fwd_data      (fwd_data),
      .fwd_stall     (fwd_stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic sq_entry_t mk(input logic r, input logic [3:0] ub,
                                    input logic [31:0] a, input logic [31:0] d);
      sq_entry_t e;
      e.ready    = r;
      e.usebytes = ub;
      e.addr     = a;
      e.data     = d;
      return e;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      dispatch    = '0;
      exe_valid   = '0;
      exe_idx     = '0;
      exe_store   = '0;
      retire      = '0;
      squash      = 1'b0;
      ld_valid    = 1'b0;
      ld_addr     = '0;
      ld_usebytes = '0;
      ld_tail     = '0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      ld_valid = 1'b1; ld_addr = 32'h100; ld_usebytes = 4'hf; ld_tail = 4'd0;
      #1;
      total++; if (struct_stall !== 3'b000) begin bad++; $display("FAIL reset_stall: got %b want 000", struct_stall); end
      total++; if (dut.count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", dut.count); end
      total++; if (dut.head_ptr !== 4'd0 || dut.tail_ptr !== 4'd0) begin bad++; $display("FAIL reset_ptrs: got %h/%h want 0/0", dut.head_ptr, dut.tail_ptr); end
      total++; if (cache_wb !== '0) begin bad++; $display("FAIL reset_cache_wb: got %h want 0", cache_wb); end
      total++; if ({fwd_stall, fwd_bytes, fwd_data} !== '0) begin bad++; $display("FAIL reset_fwd: got %b %b %h want 0", fwd_stall, fwd_bytes, fwd_data); end
      idle();
   endtask

   task automatic test_fill();
      dispatch = 3'b111;
      #1;
      total++; if (new_entry_idx !== {3'd2, 3'd1, 3'd0}) begin bad++; $display("FAIL fill_idx0: got %h want 088", new_entry_idx); end
      step();
      total++; if (new_entry_idx !== {3'd5, 3'd4, 3'd3}) begin bad++; $display("FAIL fill_idx1: got %h want %h", new_entry_idx, {3'd5, 3'd4, 3'd3}); end
      total++; if (struct_stall !== 3'b000) begin bad++; $display("FAIL fill_stall3: got %b want 000", struct_stall); end
      step();
      dispatch = 3'b011;
      #1;
      total++; if (struct_stall !== 3'b100) begin bad++; $display("FAIL fill_stall6: got %b want 100", struct_stall); end
      total++; if (new_entry_idx[0] !== 3'd6 || new_entry_idx[1] !== 3'd7) begin bad++; $display("FAIL fill_idx2: got %0d,%0d want 6,7", new_entry_idx[0], new_entry_idx[1]); end
      step();
      dispatch = 3'b000;
      #1;
      total++; if (struct_stall !== 3'b111) begin bad++; $display("FAIL fill_stall8: got %b want 111", struct_stall); end
      total++; if (dut.count !== 4'd8 || dut.tail_ptr !== 4'b1000) begin bad++; $display("FAIL fill_count: got %0d tail %b want 8 tail 1000", dut.count, dut.tail_ptr); end
   endtask

   task automatic test_execute();
      exe_valid    = 2'b11;
      exe_idx[0]   = 3'd5; exe_store[0] = mk(1'b1, 4'b0011, 32'hbc, 32'h2300);
      exe_idx[1]   = 3'd7; exe_store[1] = mk(1'b1, 4'b0011, 32'hff, 32'h2345);
      step();
      exe_valid = 2'b00;
      total++; if (dut.entries[5] !== mk(1'b1, 4'b0011, 32'hbc, 32'h2300)) begin bad++; $display("FAIL exe_entry5: got %h", dut.entries[5]); end
      total++; if (dut.entries[7] !== mk(1'b1, 4'b0011, 32'hff, 32'h2345)) begin bad++; $display("FAIL exe_entry7: got %h", dut.entries[7]); end
      total++; if (dut.entries[6] !== '0 || dut.entries[4] !== '0) begin bad++; $display("FAIL exe_untouched: got %h %h want 0", dut.entries[6], dut.entries[4]); end
   endtask

   task automatic test_retire();
      total++; if (cache_wb[0].ready !== 1'b0) begin bad++; $display("FAIL ret_head_notready: got %b want 0", cache_wb[0].ready); end
      exe_valid  = 2'b11;
      exe_idx[0] = 3'd0; exe_store[0] = mk(1'b1, 4'hf, 32'h40, 32'h11111111);
      exe_idx[1] = 3'd1; exe_store[1] = mk(1'b1, 4'hf, 32'h44, 32'h22222222);
      step();
      exe_valid  = 2'b01;
      exe_idx[0] = 3'd2; exe_store[0] = mk(1'b1, 4'hf, 32'h48, 32'h33333333);
      step();
      exe_valid = 2'b00;
      total++; if (cache_wb[2] !== mk(1'b1, 4'hf, 32'h48, 32'h33333333)) begin bad++; $display("FAIL ret_wb2: got %h", cache_wb[2]); end
      retire = 3'b111;
      #1;
      total++; if (struct_stall !== 3'b111) begin bad++; $display("FAIL ret_no_bypass: got %b want 111", struct_stall); end
      step();
      retire = 3'b000;
      total++; if (dut.head_ptr !== 4'd3 || dut.count !== 4'd5) begin bad++; $display("FAIL ret_head_count: got %0d %0d want 3 5", dut.head_ptr, dut.count); end
      total++; if (dut.entries[0] !== '0 || dut.entries[1] !== '0 || dut.entries[2] !== '0) begin bad++; $display("FAIL ret_cleared: got %h %h %h want 0", dut.entries[0], dut.entries[1], dut.entries[2]); end
      total++; if (cache_wb[2] !== mk(1'b1, 4'b0011, 32'hbc, 32'h2300)) begin bad++; $display("FAIL ret_wb_after: got %h want entry5", cache_wb[2]); end
   endtask

   task automatic test_wrap();
      dispatch = 3'b111;
      #1;
      total++; if (new_entry_idx !== {3'd2, 3'd1, 3'd0}) begin bad++; $display("FAIL wrap_idx: got %h want 088", new_entry_idx); end
      step();
      dispatch = 3'b000;
      total++; if (dut.tail_ptr !== 4'b1011 || dut.count !== 4'd8) begin bad++; $display("FAIL wrap_tail_count: got %b %0d want 1011 8", dut.tail_ptr, dut.count); end
   endtask

   task automatic test_forward();
      exe_valid  = 2'b11;
      exe_idx[0] = 3'd3; exe_store[0] = mk(1'b1, 4'b0011, 32'h100, 32'h2345);
      exe_idx[1] = 3'd4; exe_store[1] = mk(1'b1, 4'b0010, 32'h100, 32'hab00);
      step();
      exe_valid   = 2'b00;
      ld_valid    = 1'b1; ld_addr = 32'h100; ld_usebytes = 4'b0011; ld_tail = 4'b0101;
      #1;
      total++; if (fwd_bytes !== 4'b0011 || fwd_data !== 32'h0000ab45 || fwd_stall !== 1'b0) begin bad++; $display("FAIL fwd_young_old: got %b %h %b want 0011 0000ab45 0", fwd_bytes, fwd_data, fwd_stall); end
      ld_tail = 4'b0100; ld_addr = 32'h102;
      #1;
      total++; if (fwd_bytes !== 4'b0011 || fwd_data !== 32'h00002345 || fwd_stall !== 1'b0) begin bad++; $display("FAIL fwd_one_older: got %b %h %b want 0011 00002345 0", fwd_bytes, fwd_data, fwd_stall); end
      ld_tail = 4'b0101; ld_usebytes = 4'b0100;
      #1;
      total++; if (fwd_bytes !== 4'b0000 || fwd_data !== 32'h0 || fwd_stall !== 1'b0) begin bad++; $display("FAIL fwd_no_lane: got %b %h %b want 0 0 0", fwd_bytes, fwd_data, fwd_stall); end
      ld_usebytes = 4'b0011; ld_valid = 1'b0;
      #1;
      total++; if ({fwd_stall, fwd_bytes, fwd_data} !== '0) begin bad++; $display("FAIL fwd_invalid: got %b %b %h want 0", fwd_stall, fwd_bytes, fwd_data); end
      exe_valid  = 2'b01;
      exe_idx[0] = 3'd4; exe_store[0] = mk(1'b0, 4'b0010, 32'h100, 32'hab00);
      step();
      exe_valid = 2'b00;
      ld_valid  = 1'b1;
      #1;
      total++; if (fwd_stall !== 1'b1 || fwd_bytes !== 4'b0000) begin bad++; $display("FAIL fwd_stall: got %b %b want 1 0000", fwd_stall, fwd_bytes); end
      ld_tail = 4'b1011;
      #1;
      total++; if (fwd_stall !== 1'b1 || fwd_bytes !== 4'b0000) begin bad++; $display("FAIL fwd_full_stall: got %b %b want 1 0000", fwd_stall, fwd_bytes); end
      ld_valid = 1'b0; ld_tail = '0; ld_usebytes = '0; ld_addr = '0;
   endtask

   task automatic test_squash();
      squash = 1'b1; retire = 3'b001; dispatch = 3'b111;
      step();
      squash = 1'b0; retire = 3'b000; dispatch = 3'b000;
      #1;
      total++; if (dut.head_ptr !== 4'b0100 || dut.tail_ptr !== 4'b0100) begin bad++; $display("FAIL sq_ptrs: got %b %b want 0100 0100", dut.head_ptr, dut.tail_ptr); end
      total++; if (dut.count !== 4'd0 || struct_stall !== 3'b000) begin bad++; $display("FAIL sq_count_stall: got %0d %b want 0 000", dut.count, struct_stall); end
      total++; if (dut.entries !== '0) begin bad++; $display("FAIL sq_entries: got %h want 0", dut.entries); end
      total++; if (cache_wb !== '0) begin bad++; $display("FAIL sq_cache_wb: got %h want 0", cache_wb); end
   endtask

   task automatic test_exe_conflict();
      dispatch = 3'b001;
      #1;
      total++; if (new_entry_idx[0] !== 3'd4) begin bad++; $display("FAIL cf_idx: got %0d want 4", new_entry_idx[0]); end
      step();
      dispatch   = 3'b000;
      exe_valid  = 2'b11;
      exe_idx[0] = 3'd4; exe_store[0] = mk(1'b1, 4'b0001, 32'h200, 32'h000000aa);
      exe_idx[1] = 3'd4; exe_store[1] = mk(1'b1, 4'b0010, 32'h200, 32'h0000bb00);
      step();
      exe_valid = 2'b00;
      total++; if (dut.entries[4] !== mk(1'b1, 4'b0010, 32'h200, 32'h0000bb00)) begin bad++; $display("FAIL cf_port1_wins: got %h", dut.entries[4]); end
      total++; if (cache_wb[1] !== '0 || cache_wb[0] !== mk(1'b1, 4'b0010, 32'h200, 32'h0000bb00)) begin bad++; $display("FAIL cf_cache_wb: got %h", cache_wb); end
      ld_valid = 1'b1; ld_addr = 32'h200; ld_usebytes = 4'b0011; ld_tail = 4'b0101;
      #1;
      total++; if (fwd_bytes !== 4'b0010 || fwd_data !== 32'h0000bb00 || fwd_stall !== 1'b0) begin bad++; $display("FAIL cf_fwd: got %b %h %b want 0010 0000bb00 0", fwd_bytes, fwd_data, fwd_stall); end
      idle();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_execute();
      test_retire();
      test_wrap();
      test_forward();
      test_squash();
      test_exe_conflict();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
